// File: rtl/seqdet_rr_sched_if.sv
// Handshake bundle for the shared "010" detector:
// requester-side signals, grant/hit status and counter readout.
interface seqdet_rr_sched_if #(
    parameter int NCH  = 4,
    parameter int CW   = 2,
    parameter int CNTW = 8
);
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  din;
    logic [NCH-1:0]  clr;
    logic [NCH-1:0]  gnt;
    logic            hit;
    logic [CW-1:0]   hit_ch;
    logic [CW-1:0]   cnt_sel;
    logic [CNTW-1:0] cnt_out;

    modport master (
        output req, din, clr, cnt_sel,
        input  gnt, hit, hit_ch, cnt_out
    );

    modport slave (
        input  req, din, clr, cnt_sel,
        output gnt, hit, hit_ch, cnt_out
    );
endinterface

// File: rtl/seqdet_rr_sched.sv
// Round-robin time-multiplexed "010" Mealy detector.
// Per-channel saved context and saturating hit counter.
module seqdet_rr_sched #(
    parameter int NCH  = 4,
    parameter int CW   = 2,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst,
    seqdet_rr_sched_if.slave  bus
);

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

    logic [NCH-1:0][1:0]      ctx_q, ctx_d;
    logic [NCH-1:0][CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]            ptr_q, ptr_d;
    logic                     hit_q, hit_d;
    logic [CW-1:0]            hit_ch_q, hit_ch_d;

    logic [NCH-1:0] elig;
    logic [NCH-1:0] gnt;
    logic           gnt_vld;
    logic [CW-1:0]  gnt_idx;
    logic [1:0]     cur;
    logic           bit_in;
    logic [1:0]     nxt;
    logic           hit_now;

    // Rotating priority search starting just after the last winner.
    always_comb begin
        elig    = bus.req & ~bus.clr;
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= NCH; i++) begin
            logic [CW-1:0] idx;
            idx = ptr_q + CW'(i);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Shared engine: next state and hit for the granted channel.
    always_comb begin
        cur     = ctx_q[gnt_idx];
        bit_in  = bus.din[gnt_idx];
        nxt     = S0;
        hit_now = 1'b0;
        unique case (cur)
            S0: nxt = bit_in ? S0 : S1;
            S1: nxt = bit_in ? S2 : S1;
            S2: begin
                nxt     = bit_in ? S0 : S1;
                hit_now = !bit_in;
            end
            default: nxt = S0;
        endcase
    end

    // Commit the granted bit; clears override masked channels.
    always_comb begin
        ctx_d    = ctx_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        hit_d    = 1'b0;
        hit_ch_d = hit_ch_q;
        if (gnt_vld) begin
            ctx_d[gnt_idx] = nxt;
            ptr_d          = gnt_idx;
            hit_d          = hit_now;
            hit_ch_d       = gnt_idx;
            if (hit_now && (cnt_q[gnt_idx] != {CNTW{1'b1}})) begin
                cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNTW'(1);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (bus.clr[k]) begin
                ctx_d[k] = S0;
                cnt_d[k] = '0;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_q    <= '0;
            cnt_q    <= '0;
            ptr_q    <= CW'(NCH - 1);
            hit_q    <= 1'b0;
            hit_ch_q <= '0;
        end else begin
            ctx_q    <= ctx_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            hit_q    <= hit_d;
            hit_ch_q <= hit_ch_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.hit     = hit_q;
    assign bus.hit_ch  = hit_ch_q;
    assign bus.cnt_out = cnt_q[bus.cnt_sel];

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Directed bench for seqdet_rr_sched.
// One task per scenario, inline expected values.
module tb_seqdet_rr_sched;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seqdet_rr_sched_if #(.NCH(4), .CW(2), .CNTW(8)) bus ();

    seqdet_rr_sched #(.NCH(4), .CW(2), .CNTW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        bus.req = 4'b0000;
        bus.din = 4'b0000;
        bus.clr = 4'b1111;
        cyc();
        bus.clr = 4'b0000;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.req     = 4'b1111;
        bus.din     = 4'b0000;
        bus.clr     = 4'b0000;
        bus.cnt_sel = 2'd0;
        #2;
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_hit got=%b exp=0", bus.hit);
        end
        checks++;
        if (bus.hit_ch !== 2'd0) begin
            failures++;
            $display("FAIL reset_hit_ch got=%0d exp=0", bus.hit_ch);
        end
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=0001", bus.gnt);
        end
        for (int k = 0; k < 4; k++) begin
            bus.cnt_sel = 2'(k);
            #1;
            checks++;
            if (bus.cnt_out !== 8'd0) begin
                failures++;
                $display("FAIL reset_cnt%0d got=%0d exp=0", k, bus.cnt_out);
            end
        end
        cyc();
        cyc();
        bus.req = 4'b0000;
        rst     = 1'b0;
        #1;
    endtask

    task automatic test_single();
        logic [4:0] bits;
        bits        = 5'b01010;
        bus.req     = 4'b0001;
        bus.cnt_sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            bus.din[0] = bits[4 - i];
            #1;
            checks++;
            if (bus.gnt !== 4'b0001) begin
                failures++;
                $display("FAIL single_gnt%0d got=%b exp=0001", i, bus.gnt);
            end
            cyc();
            checks++;
            if (bus.hit !== ((i == 2) || (i == 4))) begin
                failures++;
                $display("FAIL single_hit%0d got=%b", i, bus.hit);
            end
            checks++;
            if (bus.hit_ch !== 2'd0) begin
                failures++;
                $display("FAIL single_hit_ch%0d got=%0d exp=0", i, bus.hit_ch);
            end
        end
        bus.req = 4'b0000;
        #1;
        checks++;
        if (bus.cnt_out !== 8'd2) begin
            failures++;
            $display("FAIL single_cnt got=%0d exp=2", bus.cnt_out);
        end
    endtask

    task automatic test_rr();
        bit stream [4][3];
        logic [3:0] exp_gnt;
        logic       exp_hit;
        stream = '{'{1, 1, 1}, '{0, 1, 0}, '{0, 0, 0}, '{1, 0, 1}};
        clear_all();
        bus.req = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < 4; k++) begin
                bus.din[k] = stream[k][c / 4];
            end
            exp_gnt = 4'b0001 << ((c + 1) % 4);
            #1;
            checks++;
            if (bus.gnt !== exp_gnt) begin
                failures++;
                $display("FAIL rr_gnt%0d got=%b exp=%b", c, bus.gnt, exp_gnt);
            end
            cyc();
            exp_hit = (c == 8);
            checks++;
            if (bus.hit !== exp_hit) begin
                failures++;
                $display("FAIL rr_hit%0d got=%b exp=%b", c, bus.hit, exp_hit);
            end
            if (exp_hit) begin
                checks++;
                if (bus.hit_ch !== 2'd1) begin
                    failures++;
                    $display("FAIL rr_hit_ch got=%0d exp=1", bus.hit_ch);
                end
            end
        end
        bus.req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            bus.cnt_sel = 2'(k);
            #1;
            checks++;
            if (bus.cnt_out !== ((k == 1) ? 8'd1 : 8'd0)) begin
                failures++;
                $display("FAIL rr_cnt%0d got=%0d", k, bus.cnt_out);
            end
        end
        bus.req = 4'b1000;
        bus.din = 4'b0000;
        cyc();
        checks++;
        if (bus.hit !== 1'b1 || bus.hit_ch !== 2'd3) begin
            failures++;
            $display("FAIL rr_ch3_ctx got=%b/%0d exp=1/3", bus.hit, bus.hit_ch);
        end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        clear_all();
        bus.req     = 4'b0100;
        bus.cnt_sel = 2'd2;
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 3; j++) begin
                bus.din[2] = (j == 1);
                cyc();
            end
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            checks++;
            if (bus.hit !== 1'b1) begin
                failures++;
                $display("FAIL sat_hit%0d got=%b exp=1", i, bus.hit);
            end
            checks++;
            if (bus.cnt_out !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, bus.cnt_out, exp_cnt);
            end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_clear();
        logic [3:0] bits;
        bits = 4'b0101;
        clear_all();
        bus.req     = 4'b1000;
        bus.cnt_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            bus.din[3] = bits[3 - i];
            cyc();
        end
        checks++;
        if (bus.cnt_out !== 8'd1) begin
            failures++;
            $display("FAIL clr_pre_cnt got=%0d exp=1", bus.cnt_out);
        end
        bus.clr = 4'b1000;
        bus.req = 4'b1001;
        bus.din = 4'b0000;
        #1;
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL clr_gnt got=%b exp=0001", bus.gnt);
        end
        cyc();
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL clr_hit got=%b exp=0", bus.hit);
        end
        checks++;
        if (bus.cnt_out !== 8'd0) begin
            failures++;
            $display("FAIL clr_cnt got=%0d exp=0", bus.cnt_out);
        end
        bus.clr = 4'b0000;
        bus.req = 4'b1000;
        bus.din = 4'b0000;
        cyc();
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL clr_post0_hit got=%b exp=0", bus.hit);
        end
        bus.din[3] = 1'b1;
        cyc();
        bus.din[3] = 1'b0;
        cyc();
        checks++;
        if (bus.hit !== 1'b1 || bus.cnt_out !== 8'd1) begin
            failures++;
            $display("FAIL clr_s1_hit got=%b/%0d exp=1/1", bus.hit, bus.cnt_out);
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_async_rst();
        logic [2:0] bits;
        bits = 3'b010;
        clear_all();
        bus.req     = 4'b0001;
        bus.cnt_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            bus.din[0] = bits[2 - i];
            cyc();
        end
        checks++;
        if (bus.hit !== 1'b1 || bus.cnt_out !== 8'd1) begin
            failures++;
            $display("FAIL arst_pre got=%b/%0d exp=1/1", bus.hit, bus.cnt_out);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL arst_hit got=%b exp=0", bus.hit);
        end
        checks++;
        if (bus.cnt_out !== 8'd0) begin
            failures++;
            $display("FAIL arst_cnt got=%0d exp=0", bus.cnt_out);
        end
        bus.req = 4'b1111;
        #1;
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL arst_gnt_in_rst got=%b exp=0001", bus.gnt);
        end
        cyc();
        checks++;
        if (bus.hit !== 1'b0 || bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL arst_hold got=%b/%b exp=0/0001", bus.hit, bus.gnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL arst_first_gnt got=%b exp=0001", bus.gnt);
        end
        cyc();
        checks++;
        if (bus.hit !== 1'b0 || bus.hit_ch !== 2'd0) begin
            failures++;
            $display("FAIL arst_first_out got=%b/%0d exp=0/0", bus.hit, bus.hit_ch);
        end
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL arst_second_gnt got=%b exp=0010", bus.gnt);
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_idle();
        clear_all();
        bus.req = 4'b0100;
        bus.din = 4'b0000;
        cyc();
        checks++;
        if (bus.hit_ch !== 2'd2) begin
            failures++;
            $display("FAIL idle_first_ch got=%0d exp=2", bus.hit_ch);
        end
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.gnt !== 4'b0000) begin
                failures++;
                $display("FAIL idle_gnt%0d got=%b exp=0000", i, bus.gnt);
            end
            cyc();
            checks++;
            if (bus.hit !== 1'b0 || bus.hit_ch !== 2'd2) begin
                failures++;
                $display("FAIL idle_out%0d got=%b/%0d exp=0/2", i, bus.hit, bus.hit_ch);
            end
        end
        bus.req = 4'b1111;
        #1;
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL idle_resume_gnt got=%b exp=1000", bus.gnt);
        end
        bus.req = 4'b0000;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_rr();
        test_saturate();
        test_clear();
        test_async_rst();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seqdet_rr_sched.md
Name: seqdet_rr_sched

Overview:
Shares one Mealy "010" sequence-detection engine among NCH serial input channels using round-robin time multiplexing. Each channel has its own saved detector state (context) and a saturating hit counter. At most one channel's bit is consumed per clock. The block sits between the serial front-end requesters and the status and counter readout logic.

Parameters:
NCH, 4, number of requesting channels; must equal 2**CW.
CW, 2, channel index width.
CNTW, 8, width of each per-channel hit counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
req  input  NCH  per-channel request: a serial bit is presented on din[k].
din  input  NCH  per-channel serial data bit; valid while req[k]=1.
clr  input  NCH  per-channel synchronous clear of context and counter.
gnt  output  NCH  one-hot grant, combinational; din[k] is consumed at the clock edge where gnt[k]=1.
hit  output  1  registered one-cycle pulse: the "010" pattern completed on the last granted bit.
hit_ch  output  CW  registered index of the last granted channel.
cnt_sel  input  CW  counter read select.
cnt_out  output  CNTW  combinational value of counter[cnt_sel].

Behaviour:
- Reset (async, rst=1):
  - All contexts = S0; all counters = 0.
  - Pointer ptr = NCH-1, so channel 0 has first priority.
  - hit = 0, hit_ch = 0.
  - gnt follows req combinationally even during reset, but no state updates while rst=1.
- Arbitration:
  - eligible = req & ~clr.
  - Search eligible from index ptr+1 upward, modulo NCH; the first set bit k gets gnt[k] = 1.
  - gnt = 0 when eligible = 0.
  - On a grant edge, ptr <= k. With no grant, ptr holds.
  - A requester holding req high is granted at least once every NCH cycles.
- Engine: per-channel 2-bit context, states S0=00, S1=01, S2=10. Transitions on the granted bit d:
  - S0: d=1 -> S0; d=0 -> S1.
  - S1: d=1 -> S2; d=0 -> S1.
  - S2: d=1 -> S0; d=0 -> S1, and produce a hit.
  - S3 (illegal): -> S0, no hit.
  - Detection overlaps: the terminating 0 starts a new prefix.
  - Only the granted channel's context changes; all other contexts hold.
- Outputs and latency:
  - Edge of a grant to channel k: hit <= (ctx[k]==S2 && din[k]==0), hit_ch <= k.
  - Edge with no grant: hit <= 0, hit_ch holds.
  - So hit is visible in the cycle after the bit is consumed.
- Counters: on the same edge as a hit, counter[k] increments. It saturates at 2**CNTW-1 and never wraps.
- Clear: clr[k]=1 at an edge sets ctx[k] <= S0 and counter[k] <= 0. Channel k is masked from arbitration that cycle, so its bit is not consumed and there is no hit from k. Other channels arbitrate normally.
- Simultaneous events:
  - clr on one channel and a grant to another are fully independent.
  - A hit on channel k with counter[cnt_sel=k] shows the new value in cnt_out the cycle after the edge.

Test Plan:
1. Only req[0]=1, din[0] = 0,1,0,1,0 on consecutive cycles -> gnt=0001 every cycle; hit pulses in the cycles after the 3rd and 5th bits with hit_ch=0; cnt_sel=0 reads cnt_out=2.
2. req=1111 held, every channel fed its own stream -> gnt sequence 0001,0010,0100,1000,0001…; ch1 sees 0,1,0 across its slots (cycles 2,6,10) -> exactly one hit, in cycle 11, with hit_ch=1; other channels' contexts are unaffected.
3. Channel 2 fed "010" repeated 300 times -> counter[2] = 255 and stays there; hit still pulses each time.
4. Channel 3 driven to S2, then clr[3]=1 with req=1001 and din[3]=0 -> gnt=0001, no hit; next bit 0 on ch3 leads to S1 only; counter[3]=0.
5. Assert rst asynchronously mid-stream -> hit=0 and all counters 0 immediately; after release with req=1111 the first grant goes to ch0.
6. req=0000 for 5 cycles after a grant to ch2 -> gnt=0, hit=0, hit_ch=2 held; then req=1111 -> next grant goes to ch3.
